// File: rtl/lfsr_rng.sv
// lfsr_rng: XNOR Fibonacci LFSR random source for game logic.
//
// The LFSR provides a free-running stream (state_out_o). It also serves
// bounded draws that return a value uniformly distributed in [0, limit) by
// rejection sampling. Only MAX_TRIES candidates are examined per draw.
//
// Ports:
//   clk           clock
//   reset         synchronous reset, active-high
//   enable_i      step the stream once per cycle while IDLE
//   load_i        load seed_i into the state (highest priority after reset)
//   seed_i        seed value; all-ones is replaced by zero
//   req_i         draw request, accepted only in IDLE
//   limit_i       exclusive upper bound, captured when the request is accepted
//   busy_o        high while a draw is searching
//   valid_o       one-cycle pulse announcing value_o / timeout_o
//   value_o       draw result, held until the next valid_o
//   timeout_o     qualifies valid_o: the draw ran out of tries
//   state_out_o   current LFSR state (raw stream)
//   fsm_state_o   FSM state for observation (0 = IDLE, 1 = SEARCH)
//
// Handshake: req_i is a request with no ready signal. It is taken on any
// IDLE cycle in which load_i is low. While busy_o is high it is ignored
// and is not queued. Every accepted draw produces exactly one valid_o pulse,
// unless a load or a reset aborts the draw first. valid_o has no
// backpressure.
//
// Each accepted draw examines N candidates, where N is between 1 and
// MAX_TRIES. valid_o rises N+1 cycles after the accepting edge. The decision
// is staged in a pending register for one cycle before it is published.

module lfsr_rng #(
    parameter int               WIDTH      = 10,
    parameter logic [WIDTH-1:0] TAPS       = 10'b0000001001,
    parameter logic [WIDTH-1:0] RESET_SEED = '0,
    parameter int               MAX_TRIES  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             req_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] value_o,
    output logic             timeout_o,
    output logic [WIDTH-1:0] state_out_o,
    output logic             fsm_state_o
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    // Pending result: set on the deciding SEARCH edge, published one edge later.
    logic             done_q, done_d;
    logic [WIDTH-1:0] res_value_q, res_value_d;
    logic             res_timeout_q, res_timeout_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             timeout_q, timeout_d;

    logic [TRY_W-1:0] tries_inc;

    // Shift right and insert the XNOR feedback as the new MSB.
    // With XNOR feedback the all-ones state is the lock-up state.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic fb;
        fb = ~(^(s & TAPS));
        return {fb, s[WIDTH-1:1]};
    endfunction

    // The try count saturates at MAX_TRIES.
    assign tries_inc = (tries_q == TRY_W'(MAX_TRIES)) ? tries_q : tries_q + TRY_W'(1);

    always_comb begin
        fsm_d         = fsm_q;
        lfsr_d        = lfsr_q;
        limit_d       = limit_q;
        tries_d       = tries_q;
        done_d        = 1'b0;
        res_value_d   = res_value_q;
        res_timeout_d = res_timeout_q;
        // Publish a pending result. Loads do not cancel it, because the
        // FSM is already IDLE by the time the result is pending.
        valid_d       = done_q;
        value_d       = done_q ? res_value_q : value_q;
        timeout_d     = done_q ? res_timeout_q : timeout_q;

        if (load_i) begin
            // A load aborts any draw in progress and discards a concurrent request.
            lfsr_d = (&seed_i) ? '0 : seed_i;
            fsm_d  = IDLE;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (enable_i) begin
                        lfsr_d = lfsr_step(lfsr_q);
                    end
                    if (req_i) begin
                        limit_d = limit_i;
                        tries_d = '0;
                        fsm_d   = SEARCH;
                    end
                end
                SEARCH: begin
                    // The current state is the candidate. In SEARCH the LFSR
                    // steps regardless of enable_i.
                    lfsr_d  = lfsr_step(lfsr_q);
                    tries_d = tries_inc;
                    if (limit_q == '0) begin
                        done_d        = 1'b1;
                        res_value_d   = '0;
                        res_timeout_d = 1'b0;
                        fsm_d         = IDLE;
                    end else if (lfsr_q < limit_q) begin
                        done_d        = 1'b1;
                        res_value_d   = lfsr_q;
                        res_timeout_d = 1'b0;
                        fsm_d         = IDLE;
                    end else if (tries_inc == TRY_W'(MAX_TRIES)) begin
                        done_d        = 1'b1;
                        res_value_d   = '0;
                        res_timeout_d = 1'b1;
                        fsm_d         = IDLE;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q         <= IDLE;
            lfsr_q        <= RESET_SEED;
            limit_q       <= '0;
            tries_q       <= '0;
            done_q        <= 1'b0;
            res_value_q   <= '0;
            res_timeout_q <= 1'b0;
            valid_q       <= 1'b0;
            value_q       <= '0;
            timeout_q     <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            lfsr_q        <= lfsr_d;
            limit_q       <= limit_d;
            tries_q       <= tries_d;
            done_q        <= done_d;
            res_value_q   <= res_value_d;
            res_timeout_q <= res_timeout_d;
            valid_q       <= valid_d;
            value_q       <= value_d;
            timeout_q     <= timeout_d;
        end
    end

    assign busy_o      = (fsm_q == SEARCH);
    assign valid_o     = valid_q;
    assign value_o     = value_q;
    assign timeout_o   = timeout_q;
    assign state_out_o = lfsr_q;
    assign fsm_state_o = fsm_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng. Instance A uses the default parameters.
// Instance B uses MAX_TRIES=4 and is used only for the timeout draw.
// Both instances share all inputs.

module tb_lfsr_rng;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       load;
    logic [9:0] seed;
    logic       req;
    logic [9:0] limit;

    logic       busy_a, valid_a, timeout_a, fsm_a;
    logic [9:0] value_a, state_a;
    logic       busy_b, valid_b, timeout_b, fsm_b;
    logic [9:0] value_b, state_b;

    int checks   = 0;
    int failures = 0;

    lfsr_rng dut_a (
        .clk(clk), .reset(reset), .enable_i(enable), .load_i(load), .seed_i(seed),
        .req_i(req), .limit_i(limit), .busy_o(busy_a), .valid_o(valid_a),
        .value_o(value_a), .timeout_o(timeout_a), .state_out_o(state_a),
        .fsm_state_o(fsm_a)
    );

    lfsr_rng #(.MAX_TRIES(4)) dut_b (
        .clk(clk), .reset(reset), .enable_i(enable), .load_i(load), .seed_i(seed),
        .req_i(req), .limit_i(limit), .busy_o(busy_b), .valid_o(valid_b),
        .value_o(value_b), .timeout_o(timeout_b), .state_out_o(state_b),
        .fsm_state_o(fsm_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Advance one clock edge, then wait 1 ns so outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        req    = 1'b0;
        seed   = '0;
        limit  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reset, then take two enabled steps so the state is 768.
    task automatic reset_to_768();
        do_reset();
        enable = 1'b1;
        tick();
        tick();
        enable = 1'b0;
    endtask

    // Present a request for one edge, which is the accepting edge.
    task automatic accept(input logic [9:0] lim);
        req   = 1'b1;
        limit = lim;
        tick();
        req = 1'b0;
    endtask

    // Count edges after the accepting edge until valid is seen.
    // Returns -1 if the bound expires.
    task automatic wait_valid(input bit use_b, input int bound, output int lat);
        lat = -1;
        for (int k = 1; k <= bound; k++) begin
            tick();
            if ((use_b ? valid_b : valid_a) === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic count_valids(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (valid_a === 1'b1) cnt++;
        end
    endtask

    // ---------------- stimulus ----------------
    int seq_exp [9] = '{0, 512, 768, 896, 960, 992, 1008, 1016, 508};
    int lat;
    int cnt;

    initial begin
        // 1. Reset values and the free-running stream.
        do_reset();
        check("rst_state", state_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_value", value_a, 0);
        check("rst_timeout", timeout_a, 0);
        check("rst_fsm", fsm_a, 0);
        enable = 1'b1;
        for (int i = 1; i < 9; i++) begin
            tick();
            check($sformatf("stream_%0d", i), state_a, seq_exp[i]);
        end
        enable = 1'b0;

        // 2. A draw with limit 600 from state 768 accepts 508 on the 7th candidate.
        reset_to_768();
        check("pre_draw_state", state_a, 768);
        accept(10'd600);
        check("draw_busy", busy_a, 1);
        check("draw_state_hold", state_a, 768);
        wait_valid(1'b0, 40, lat);
        check("draw_latency", lat, 8);
        check("draw_value", value_a, 508);
        check("draw_timeout", timeout_a, 0);
        check("draw_busy_done", busy_a, 0);
        tick();
        check("valid_one_cycle", valid_a, 0);
        check("value_held", value_a, 508);
        check("post_draw_state", state_a, 254);

        // 6a. A limit of 0 returns 0 after one candidate.
        accept(10'd0);
        wait_valid(1'b0, 20, lat);
        check("lim0_latency", lat, 2);
        check("lim0_value", value_a, 0);
        check("lim0_timeout", timeout_a, 0);

        // 3. With MAX_TRIES=4, limit 1 from state 768 times out.
        reset_to_768();
        accept(10'd1);
        wait_valid(1'b1, 20, lat);
        check("to_latency", lat, 5);
        check("to_value", value_b, 0);
        check("to_timeout", timeout_b, 1);

        // 4. Seed loads, including the all-ones lock-up replacement.
        do_reset();
        seed = 10'h3FF;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("load_ones", state_a, 0);
        seed = 10'h155;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("load_155", state_a, 'h155);

        // 5a. A load in the 3rd SEARCH cycle aborts the draw.
        reset_to_768();
        accept(10'd600);
        tick();
        tick();
        check("abort_pre_state", state_a, 960);
        seed = 10'd5;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("abort_state", state_a, 5);
        check("abort_fsm", fsm_a, 0);
        check("abort_busy", busy_a, 0);
        count_valids(15, cnt);
        check("abort_no_valid", cnt, 0);
        check("abort_state_kept", state_a, 5);

        // 5b. A reset in mid-SEARCH abandons the draw.
        reset_to_768();
        accept(10'd600);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_state", state_a, 0);
        check("rst_mid_busy", busy_a, 0);
        count_valids(15, cnt);
        check("rst_mid_no_valid", cnt, 0);

        // 6b. req is held high while busy, and limit changes, but neither is taken.
        reset_to_768();
        req   = 1'b1;
        limit = 10'd600;
        tick();
        limit = 10'd0;
        cnt   = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (valid_a === 1'b1) cnt++;
        end
        req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (valid_a === 1'b1) begin
                cnt++;
                check("hold_value", value_a, 508);
            end
        end
        check("hold_one_valid", cnt, 1);

        // 6c. A req in the valid cycle is accepted.
        reset_to_768();
        accept(10'd600);
        wait_valid(1'b0, 40, lat);
        check("b2b_first_lat", lat, 8);
        accept(10'd0);
        check("b2b_busy", busy_a, 1);
        wait_valid(1'b0, 20, lat);
        check("b2b_second_lat", lat, 2);
        check("b2b_value", value_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
Parametrised XNOR Fibonacci LFSR random source for game logic such as spawn lanes, obstacle columns and timing jitter. Supports a free-running stream, a seed load, and a bounded-draw handshake. A draw returns a value uniformly in [0, limit) by rejection sampling, with a bounded retry count. One instance per random consumer; all instances share clk.

Parameters:
WIDTH, 10, LFSR state width in bits (>=3).
TAPS, 10'b0000001001, feedback tap mask over state bits; feedback = XNOR-reduction of (state & TAPS). The default gives x^10+x^7+1.
RESET_SEED, 0, state value loaded on reset; must not be all-ones.
MAX_TRIES, 16, candidates examined per draw before timeout (>=1).

Ports:
clk  input  1  clock.
reset  input  1  synchronous reset, active-high.
enable  input  1  advance the free-running stream one step per cycle while IDLE.
load  input  1  load seed into state this cycle.
seed  input  WIDTH  seed value used with load.
req  input  1  draw request; sampled only in IDLE.
limit  input  WIDTH  exclusive upper bound for the draw; captured on request accept.
busy  output  1  high while the FSM is in SEARCH.
valid  output  1  one-cycle pulse when value is ready.
value  output  WIDTH  draw result; held until the next valid.
timeout  output  1  qualifies valid; high if the draw hit MAX_TRIES.
state_out  output  WIDTH  current LFSR state (raw stream).

Behaviour:
- Step function: next = {fb, state[WIDTH-1:1]} (shift right, new MSB = fb). All-ones is the lock-up state.
- Reset: state=RESET_SEED, FSM=IDLE, busy=0, valid=0, value=0, timeout=0, try counter=0, captured limit=0. Reset mid-draw abandons the draw and produces no valid.
- Priority each cycle: reset > load > FSM/enable stepping.
- load: state<=seed. If seed is all-ones, state<=0 instead (lock-up avoidance). In SEARCH, load aborts the draw: FSM->IDLE, no valid. A load in the same cycle as req also discards the req.
- IDLE: if enable, state advances one step. If req, capture limit, clear try counter, FSM->SEARCH next cycle. Enable is ignored in SEARCH, where the LFSR steps unconditionally.
- SEARCH, one candidate per cycle: candidate = current state; the state steps; the try counter increments.
  - If captured limit == 0: value<=0, timeout<=0, valid next cycle, FSM->IDLE on the first SEARCH cycle.
  - Else if candidate < limit (unsigned): value<=candidate, timeout<=0, valid next cycle, FSM->IDLE.
  - Else if try count reaches MAX_TRIES: value<=0, timeout<=1, valid next cycle, FSM->IDLE.
- Latency: valid asserts N+1 cycles after the req-accept edge, where N = number of candidates examined (1..MAX_TRIES).
- valid is high for exactly one cycle. req asserted while busy is ignored, with no queuing. A new req in the valid cycle (FSM already IDLE) is accepted.
- The try counter is $clog2(MAX_TRIES+1) bits and saturates; the comparison is pure unsigned over WIDTH bits.

Test Plan:
1. Reset, then enable=1 for 8 cycles -> state_out sequence 0,512,768,896,960,992,1008,1016,508.
2. After reset with 2 enabled steps (state 768), req with limit=600 -> candidates 768,896,960,992,1008,1016 rejected, 508 accepted; valid at accept+8 with value=508, timeout=0.
3. MAX_TRIES=4, state 768, req with limit=1 -> 4 rejects; valid at accept+5 with value=0, timeout=1.
4. load with seed=10'h3FF -> state_out=0 next cycle. load with seed=10'h155 -> state_out=0x155.
5. Abort: req with limit=600 from state 768, load seed 5 in the 3rd SEARCH cycle -> no valid, FSM IDLE, state_out=5. Separately, reset asserted mid-SEARCH -> no valid, state=RESET_SEED.
6. Edge cases: limit=0 -> valid at accept+2 with value=0. req held high while busy -> exactly one valid. Back-to-back req in the valid cycle -> second draw accepted.
